balls_draw: RTL and testbench

BALLS_DRAW -- requirements
Module: balls_draw

---
 rtl/balls_pkg.sv | 46 ++++
 rtl/ball_mask_rom.sv | 31 +++
 rtl/balls_draw.sv | 191 +++++++++++++++++++
 tb/tb_balls_draw.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/balls_pkg.sv
// Shared types and constants for the ball sprite renderer.
// Mask encoding, per-ball state, palette constants and the procedural sprite shape.
package balls_pkg;

    localparam int MAX_BALLS = 8;

    localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;
    localparam logic [7:0] BLACK                = 8'h00;
    localparam logic [7:0] WHITE                = 8'hFE;

    typedef enum logic [1:0] {
        MASK_TRANSP = 2'd0,
        MASK_BODY   = 2'd1,
        MASK_BLACK  = 2'd2,
        MASK_WHITE  = 2'd3
    } mask_e;

    typedef enum logic [1:0] {
        ST_VISIBLE = 2'd0,
        ST_SINKING = 2'd1,
        ST_GONE    = 2'd2
    } ball_state_e;

    // Disc of diameter s with a two-pixel black rim and a square white highlight
    // covering rows/cols [s/4, s/4+s/8). Distances use doubled coordinates.
    function automatic mask_e mask_at(input int row, input int col, input int s);
        int dx;
        int dy;
        int d2;
        int hl0;
        int hl1;
        dx  = 2 * col + 1 - s;
        dy  = 2 * row + 1 - s;
        d2  = dx * dx + dy * dy;
        hl0 = s / 4;
        hl1 = s / 4 + s / 8;
        if (d2 >= s * s)
            return MASK_TRANSP;
        if (d2 >= (s - 4) * (s - 4))
            return MASK_BLACK;
        if (row >= hl0 && row < hl1 && col >= hl0 && col < hl1)
            return MASK_WHITE;
        return MASK_BODY;
    endfunction

endpackage

// File: rtl/ball_mask_rom.sv
// Sprite mask ROM, BITMAP_SIZE x BITMAP_SIZE entries of 2 bits.
// Latency 1 cycle (registered read); no backpressure, new address every cycle.
module ball_mask_rom
    import balls_pkg::*;
#(
    parameter int BITMAP_SIZE = 32,
    localparam int AW = $clog2(BITMAP_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] row,
    input  logic [AW-1:0] col,
    output mask_e         mask
);

    mask_e rom_tbl [BITMAP_SIZE*BITMAP_SIZE];

    for (genvar r = 0; r < BITMAP_SIZE; r++) begin : g_row
        for (genvar c = 0; c < BITMAP_SIZE; c++) begin : g_col
            assign rom_tbl[r*BITMAP_SIZE + c] = mask_at(r, c, BITMAP_SIZE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            mask <= MASK_TRANSP;
        else
            mask <= rom_tbl[{row, col}];
    end

endmodule

// File: rtl/balls_draw.sv
// Multi-ball sprite renderer with per-ball pocket (sink) FSM; BALL_SINK_ANIM_EN enables the shrink animation.
// Latency 2 cycles pixel-to-colour (hit test + ROM, then palette + priority).
// No backpressure: one pixel accepted per cycle, lowest-index opaque ball wins.
module balls_draw
    import balls_pkg::*;
#(
    parameter int NUM_BALLS        = 4,
    parameter int BITMAP_SIZE      = 32,
    parameter int SINK_STEP_FRAMES = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [10:0]                 pixelX,
    input  logic [10:0]                 pixelY,
    input  logic                        startOfFrame,
    input  logic [NUM_BALLS-1:0][10:0]  topLeftPosX,
    input  logic [NUM_BALLS-1:0][10:0]  topLeftPosY,
    input  logic [NUM_BALLS-1:0]        ballShow,
    input  logic [NUM_BALLS-1:0][7:0]   ballColor,
    input  logic [NUM_BALLS-1:0]        sinkStart,
    output logic                        drawingRequestBall,
    output logic [7:0]                  RGBoutBall,
    output logic [2:0]                  hitBallIdx,
    output logic [NUM_BALLS-1:0]        sinkDone
);

    localparam int          AW     = $clog2(BITMAP_SIZE);
    localparam logic [11:0] SIZE12 = 12'(BITMAP_SIZE);

    ball_state_e                 state_q [NUM_BALLS];
    logic [NUM_BALLS-1:0]        seen_low_q;
    logic [NUM_BALLS-1:0]        sink_done_q;
    logic [NUM_BALLS-1:0]        in_box;
    logic [NUM_BALLS-1:0]        drawable;
    logic [NUM_BALLS-1:0]        hit_q;
    logic [NUM_BALLS-1:0][7:0]   color_q;
    logic [NUM_BALLS-1:0][AW-1:0] row;
    logic [NUM_BALLS-1:0][AW-1:0] col;
    mask_e                       mask [NUM_BALLS];

`ifdef BALL_SINK_ANIM_EN
    localparam int FW = (SINK_STEP_FRAMES > 1) ? $clog2(SINK_STEP_FRAMES) : 1;
    logic [1:0]    lvl_q  [NUM_BALLS];
    logic [FW-1:0] fcnt_q [NUM_BALLS];
`else
    logic sof_unused;
    assign sof_unused = startOfFrame;
`endif

    // Stage 1: box test in 12 bits so the sprite never wraps past column/row 2047.
    for (genvar i = 0; i < NUM_BALLS; i++) begin : g_ball
        logic [11:0] size;
        logic [11:0] x0;
        logic [11:0] y0;
`ifdef BALL_SINK_ANIM_EN
        assign size = SIZE12 >> lvl_q[i];
        assign x0   = {1'b0, topLeftPosX[i]} + ((SIZE12 - size) >> 1);
        assign y0   = {1'b0, topLeftPosY[i]} + ((SIZE12 - size) >> 1);
        assign col[i] = AW'({1'b0, pixelX} - x0) << lvl_q[i];
        assign row[i] = AW'({1'b0, pixelY} - y0) << lvl_q[i];
`else
        assign size = SIZE12;
        assign x0   = {1'b0, topLeftPosX[i]};
        assign y0   = {1'b0, topLeftPosY[i]};
        assign col[i] = AW'({1'b0, pixelX} - x0);
        assign row[i] = AW'({1'b0, pixelY} - y0);
`endif
        assign in_box[i] = ({1'b0, pixelX} >= x0) && ({1'b0, pixelX} < x0 + size) &&
                           ({1'b0, pixelY} >= y0) && ({1'b0, pixelY} < y0 + size);
        assign drawable[i] = (state_q[i] != ST_GONE);

        ball_mask_rom #(.BITMAP_SIZE(BITMAP_SIZE)) u_rom (
            .clk  (clk),
            .rst  (rst),
            .row  (row[i]),
            .col  (col[i]),
            .mask (mask[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q   <= '0;
            color_q <= '0;
        end else begin
            hit_q   <= in_box & ballShow & drawable;
            color_q <= ballColor;
        end
    end

    // Per-ball pocket FSM; keeps running regardless of ballShow.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                state_q[i]     <= ST_VISIBLE;
                seen_low_q[i]  <= 1'b0;
                sink_done_q[i] <= 1'b0;
`ifdef BALL_SINK_ANIM_EN
                lvl_q[i]       <= 2'd0;
                fcnt_q[i]      <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                sink_done_q[i] <= 1'b0;
                case (state_q[i])
                    ST_VISIBLE: begin
                        if (sinkStart[i]) begin
`ifdef BALL_SINK_ANIM_EN
                            state_q[i] <= ST_SINKING;
                            lvl_q[i]   <= 2'd0;
                            fcnt_q[i]  <= '0;
`else
                            state_q[i]     <= ST_GONE;
                            sink_done_q[i] <= 1'b1;
                            seen_low_q[i]  <= 1'b0;
`endif
                        end
                    end
`ifdef BALL_SINK_ANIM_EN
                    ST_SINKING: begin
                        if (startOfFrame) begin
                            if (fcnt_q[i] == FW'(SINK_STEP_FRAMES - 1)) begin
                                fcnt_q[i] <= '0;
                                if (lvl_q[i] == 2'd3) begin
                                    state_q[i]     <= ST_GONE;
                                    sink_done_q[i] <= 1'b1;
                                    seen_low_q[i]  <= 1'b0;
                                end else begin
                                    lvl_q[i] <= lvl_q[i] + 2'd1;
                                end
                            end else begin
                                fcnt_q[i] <= fcnt_q[i] + 1'b1;
                            end
                        end
                    end
`endif
                    ST_GONE: begin
                        if (!ballShow[i]) begin
                            seen_low_q[i] <= 1'b1;
                        end else if (seen_low_q[i]) begin
                            state_q[i]    <= ST_VISIBLE;
                            seen_low_q[i] <= 1'b0;
`ifdef BALL_SINK_ANIM_EN
                            lvl_q[i]      <= 2'd0;
`endif
                        end
                    end
                    default: state_q[i] <= ST_VISIBLE;
                endcase
            end
        end
    end

    assign sinkDone = sink_done_q;

    // Stage 2: palette lookup; scanning from the top index down lets ball 0 win.
    logic       nxt_draw;
    logic [7:0] nxt_rgb;
    logic [2:0] nxt_idx;

    always_comb begin
        nxt_draw = 1'b0;
        nxt_rgb  = TRANSPARENT_ENCODING;
        nxt_idx  = 3'd0;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (hit_q[i] && mask[i] != MASK_TRANSP) begin
                nxt_draw = 1'b1;
                nxt_idx  = 3'(i);
                case (mask[i])
                    MASK_BODY:  nxt_rgb = color_q[i];
                    MASK_BLACK: nxt_rgb = BLACK;
                    default:    nxt_rgb = WHITE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drawingRequestBall <= 1'b0;
            RGBoutBall         <= TRANSPARENT_ENCODING;
            hitBallIdx         <= 3'd0;
        end else begin
            drawingRequestBall <= nxt_draw;
            RGBoutBall         <= nxt_rgb;
            hitBallIdx         <= nxt_idx;
        end
    end

endmodule

// File: tb/tb_balls_draw.sv
// Scoreboard bench for balls_draw: probes push expected pixels, a monitor pops them 2 cycles later.
module tb_balls_draw;

    localparam int NB = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [10:0]     pixelX;
    logic [10:0]     pixelY;
    logic            startOfFrame;
    logic [NB-1:0][10:0] tlx;
    logic [NB-1:0][10:0] tly;
    logic [NB-1:0]   ballShow;
    logic [NB-1:0][7:0] ballColor;
    logic [NB-1:0]   sinkStart;
    logic            drawingRequestBall;
    logic [7:0]      RGBoutBall;
    logic [2:0]      hitBallIdx;
    logic [NB-1:0]   sinkDone;

    always #5 clk = ~clk;

    balls_draw #(
        .NUM_BALLS        (NB),
        .BITMAP_SIZE      (32),
        .SINK_STEP_FRAMES (2)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .pixelX             (pixelX),
        .pixelY             (pixelY),
        .startOfFrame       (startOfFrame),
        .topLeftPosX        (tlx),
        .topLeftPosY        (tly),
        .ballShow           (ballShow),
        .ballColor          (ballColor),
        .sinkStart          (sinkStart),
        .drawingRequestBall (drawingRequestBall),
        .RGBoutBall         (RGBoutBall),
        .hitBallIdx         (hitBallIdx),
        .sinkDone           (sinkDone)
    );

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        dr;
        logic [7:0]  rgb;
        logic [2:0]  idx;
    } exp_t;

    exp_t sb[$];
    logic probe_v = 1'b0;
    logic pv1 = 1'b0;
    logic pv2 = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   done_cnt[NB];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        pv1 <= probe_v;
        pv2 <= pv1;
    end

    // Monitor: output for a probe appears 2 edges after it was presented.
    always @(negedge clk) begin
        if (pv2) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_underflow: output with no expected entry");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("px(%0d,%0d) {draw,rgb,idx}", e.x, e.y),
                      {20'd0, drawingRequestBall, RGBoutBall, hitBallIdx},
                      {20'd0, e.dr, e.rgb, e.idx});
            end
        end
        for (int i = 0; i < NB; i++)
            if (sinkDone[i] === 1'b1) done_cnt[i]++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int x, input int y, input logic dr,
                         input logic [7:0] rgb, input logic [2:0] idx);
        exp_t e;
        pixelX  = 11'(x);
        pixelY  = 11'(y);
        probe_v = 1'b1;
        e.x = 11'(x); e.y = 11'(y); e.dr = dr; e.rgb = rgb; e.idx = idx;
        sb.push_back(e);
        step();
        probe_v = 1'b0;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
    endtask

`ifdef BALL_SINK_ANIM_EN
    // Ball 0 centre row (y=116): box edges for level lv; left edge samples mask col 0 (black rim).
    task automatic edges(input int lv, input logic [7:0] right_rgb);
        int sz;
        int x0;
        sz = 32 >> lv;
        x0 = 100 + (32 - sz) / 2;
        probe(x0 - 1,  116, 1'b0, 8'hFF, 3'd0);
        probe(x0,      116, 1'b1, 8'h00, 3'd0);
        probe(x0 + sz - 1, 116, 1'b1, right_rgb, 3'd0);
        probe(x0 + sz, 116, 1'b0, 8'hFF, 3'd0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NB; i++) done_cnt[i] = 0;
        rst = 1'b1;
        pixelX = '0; pixelY = '0; startOfFrame = 1'b0;
        sinkStart = '0; ballShow = '0;
        tlx[0] = 11'd100;  tly[0] = 11'd100; ballColor[0] = 8'hE0;
        tlx[1] = 11'd184;  tly[1] = 11'd34;  ballColor[1] = 8'hC0;
        tlx[2] = 11'd190;  tly[2] = 11'd40;  ballColor[2] = 8'h1C;
        tlx[3] = 11'd2030; tly[3] = 11'd300; ballColor[3] = 8'h03;
        repeat (3) step();
        check("rst_draw", {31'd0, drawingRequestBall}, 32'd0);
        check("rst_rgb",  {24'd0, RGBoutBall}, 32'hFF);
        check("rst_idx",  {29'd0, hitBallIdx}, 32'd0);
        check("rst_sinkdone", {28'd0, sinkDone}, 32'd0);
        rst = 1'b0;
        ballShow = 4'b1111;
        step();

        probe(116, 116, 1'b1, 8'hE0, 3'd0);
        probe(132, 116, 1'b0, 8'hFF, 3'd0);
        probe(100, 100, 1'b0, 8'hFF, 3'd0);
        probe(100, 116, 1'b1, 8'h00, 3'd0);
        probe(109, 109, 1'b1, 8'hFE, 3'd0);
        probe(131, 116, 1'b1, 8'h00, 3'd0);
        probe(99,  116, 1'b0, 8'hFF, 3'd0);
        probe(200, 50,  1'b1, 8'hC0, 3'd1);
        probe(206, 66,  1'b1, 8'h1C, 3'd2);
        probe(5,   316, 1'b0, 8'hFF, 3'd0);
        probe(2046, 316, 1'b1, 8'h03, 3'd3);
        ballShow[0] = 1'b0;
        probe(116, 116, 1'b0, 8'hFF, 3'd0);
        ballShow[0] = 1'b1;
        step();

`ifdef BALL_SINK_ANIM_EN
        // Start coincides with a frame pulse; that pulse must not count.
        sinkStart[0] = 1'b1; startOfFrame = 1'b1;
        step();
        sinkStart[0] = 1'b0; startOfFrame = 1'b0;
        edges(0, 8'h00); frame();
        edges(0, 8'h00); frame();
        edges(1, 8'h00); frame();
        edges(1, 8'h00); frame();
        edges(2, 8'hE0); frame();
        edges(2, 8'hE0); frame();
        edges(3, 8'hE0); frame();
        edges(3, 8'hE0);
        check("done_before_end", done_cnt[0], 0);
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        check("sinkdone_pulse", {28'd0, sinkDone}, 32'b0001);
        step();
        check("sinkdone_clear", {28'd0, sinkDone}, 32'd0);
        probe(116, 116, 1'b0, 8'hFF, 3'd0);
        check("done_count_1", done_cnt[0], 1);
        ballShow[0] = 1'b0; step();
        ballShow[0] = 1'b1; step();
        probe(116, 116, 1'b1, 8'hE0, 3'd0);

        // Abort at level 2 with reset.
        sinkStart[0] = 1'b1; step(); sinkStart[0] = 1'b0;
        repeat (4) frame();
        probe(111, 116, 1'b0, 8'hFF, 3'd0);
        probe(112, 116, 1'b1, 8'h00, 3'd0);
        step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        frame();
        probe(100, 116, 1'b1, 8'h00, 3'd0);
        probe(131, 116, 1'b1, 8'h00, 3'd0);
        probe(116, 116, 1'b1, 8'hE0, 3'd0);
        repeat (6) frame();
        check("done_after_abort", done_cnt[0], 1);
`else
        sinkStart[3] = 1'b1; step(); sinkStart[3] = 1'b0;
        check("sinkdone3_pulse", {28'd0, sinkDone}, 32'b1000);
        step();
        check("sinkdone3_clear", {28'd0, sinkDone}, 32'd0);
        probe(2046, 316, 1'b0, 8'hFF, 3'd0);
        frame();
        probe(2046, 316, 1'b0, 8'hFF, 3'd0);
        sinkStart[3] = 1'b1; step(); sinkStart[3] = 1'b0;
        check("sinkstart_in_gone", {28'd0, sinkDone}, 32'd0);
        step();
        check("done3_count", done_cnt[3], 1);
        ballShow[3] = 1'b0; step();
        ballShow[3] = 1'b1; step();
        probe(2046, 316, 1'b1, 8'h03, 3'd3);
        sinkStart[0] = 1'b1; step(); sinkStart[0] = 1'b0;
        check("sinkdone0_pulse", {28'd0, sinkDone}, 32'b0001);
        probe(116, 116, 1'b0, 8'hFF, 3'd0);
        probe(200, 50,  1'b1, 8'hC0, 3'd1);
`endif

        repeat (4) step();
        check("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
